mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
Shares one pipelined 8x8 unsigned multiplier datapath among NUM_REQ requesters.
- Round-robin arbitration over requesters; registers the winner's operands into the multiplier.
- Carries a requester tag alongside the product through a matched-latency shift pipe.
- Steers each returning 16-bit product into a per-requester result register with a valid/ready response handshake.
- Sits between the multiplier and its client blocks, all in the CLK_50M domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
PIPE_LAT, 4, multiplier latency in cycles from mul_x/mul_y sample to mul_p valid

Ports:
CLK_50M  in  1  system clock; all logic is on the rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operation request
req_x  in  8*NUM_REQ  multiplicand; requester i uses bits [8i+7:8i]
req_y  in  8*NUM_REQ  multiplier operand, same packing as req_x
req_ready  out  NUM_REQ  one-hot grant; the request is accepted when req_valid[i] and req_ready[i] are both high
mul_x  out  8  operand to multiplier, registered
mul_y  out  8  operand to multiplier, registered
mul_vld  out  1  operand slot valid, registered
mul_p  in  16  product from multiplier, valid PIPE_LAT cycles after mul_x/mul_y
rsp_valid  out  NUM_REQ  result pending for requester i
rsp_data  out  16*NUM_REQ  result for requester i, bits [16i+15:16i]
rsp_ready  in  NUM_REQ  requester i consumes its result
idle  out  1  high when nothing is in flight and no result is pending

Behaviour:
Clock and reset:
- One clock, CLK_50M. Reset is asynchronous and active-low on rst_n.
- Reset values: req_ready=0, mul_x=0, mul_y=0, mul_vld=0, rsp_valid=0, rsp_data=0, idle=1.
- Reset also clears the tag pipe, the busy flags and the RR pointer. The RR pointer resets to NUM_REQ-1, so requester 0 has first priority.

Outstanding limit and eligibility:
- Each requester has at most one outstanding operation.
- busy[i] is set on acceptance and cleared in the cycle the rsp_valid[i]/rsp_ready[i] handshake occurs.
- eligible[i] = req_valid[i] & ~busy[i].

Arbitration:
- req_ready is combinational from eligible and the RR pointer.
- The search starts at pointer+1 and wraps modulo NUM_REQ. At most one bit of req_ready is high.
- On acceptance the pointer moves to the granted index. With no eligible requester, req_ready=0 and the pointer is held.
- Requests must hold req_valid and operands stable until accepted. Dropping req_valid before grant is legal and leaves no side effect.

Issue and return:
- Acceptance in cycle t registers mul_x/mul_y/mul_vld=1 for cycle t+1. With no acceptance, mul_vld=0 and the operands are driven 0.
- The tag pipe is PIPE_LAT stages of {valid, index}. Its entry is loaded with {mul_vld, granted index}.
- When the pipe output is valid (cycle t+1+PIPE_LAT), mul_p is captured into rsp_data[index] and rsp_valid[index]=1 in cycle t+2+PIPE_LAT.
- Accept-to-rsp_valid latency is PIPE_LAT+2 cycles, which is 6 with the default.
- Throughput is one issue per cycle across requesters.
- rsp_valid[i] and rsp_data[i] are held stable until rsp_ready[i]. After consumption rsp_data keeps its last value and rsp_valid drops the next cycle.

Boundary cases:
- A response handshake and req_valid from the same requester in the same cycle: the requester is not eligible that cycle and may be granted the following cycle.
- A returning product can never collide with a pending result, because of the one-outstanding limit.
- Reset mid-operation: in-flight products are discarded. No rsp_valid may assert from pre-reset operations.
- Arithmetic is unsigned with a full 16-bit product. 255*255 gives 65025; any operand 0 gives 0.
- idle = ~|busy.

Optional Feature:
MULT_SHARE_STATS_EN
- With the macro defined, two extra outputs are added:
  - stat_issues (16-bit): counts accepted requests, saturating at 16'hFFFF.
  - stat_stall (16-bit): counts cycles where req_valid has any bit set but no request is accepted, also saturating.
- Both counters reset to 0 and are cleared only by rst_n.
- Without the macro, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
Package mult_share_pkg holds:
- OPW=8, PRODW=16, the NUM_REQ default and the PIPE_LAT default.
- tag_t, a struct of {logic vld; logic [2:0] idx}.

Sub-module rr_arbiter (NUM_REQ) takes a request vector and pointer and returns a one-hot grant and the next pointer; it is purely combinational. The tag pipe and result registers stay in the top module.

Test Plan:
1. Single op: req 0 with x=12, y=13; the bench multiplier model uses PIPE_LAT=4 -> mul_vld 1 cycle after accept; rsp_valid[0] 6 cycles after accept; rsp_data0=156.
2. Burst: all 4 requesters valid in the same cycle with x=255, y=255 (req1 y=0) -> grants in order 0,1,2,3 on consecutive cycles; responses 65025, 0, 65025, 65025 on consecutive cycles.
3. Fairness: req0 and req2 permanently re-requesting with rsp_ready=1 -> grants alternate 0,2,0,2; the inter-grant gap per requester is at least PIPE_LAT+3 cycles.
4. Backpressure: rsp_ready[1]=0 for 10 cycles after a 7*9 result -> rsp_valid[1]=1 and rsp_data1=63 stable; req_ready[1]=0 while req_valid[1]=1; requesters 0 and 3 still granted. Releasing rsp_ready -> req1 granted 1 cycle after the handshake.
5. Reset mid-flight: assert rst_n=0 two cycles after issuing 3 ops -> all outputs at reset values immediately; after release, no rsp_valid for 20 cycles and idle=1.
6. With MULT_SHARE_STATS_EN: 5 accepted ops plus 3 blocked cycles -> stat_issues=5, stat_stall=3; force 70000 issues -> stat_issues=65535.

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared widths, parameter defaults and the requester tag carried alongside
// each product through the matched-latency pipe.
package mult_share_pkg;

    localparam int unsigned OPW              = 8;
    localparam int unsigned PRODW            = 16;
    localparam int unsigned IDXW             = 3;
    localparam int unsigned NUM_REQ_DEFAULT  = 4;
    localparam int unsigned PIPE_LAT_DEFAULT = 4;

    typedef struct packed {
        logic            vld;
        logic [IDXW-1:0] idx;
    } tag_t;

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr and wraps;
// ptr_nxt is the granted index, or ptr unchanged when nothing is requesting.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDXW-1:0]    ptr_nxt
);

    localparam int N = int'(NUM_REQ);

    // Scan farthest-to-nearest so the nearest requester after ptr wins last.
    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        for (int off = N; off > 0; off--) begin
            for (int j = 0; j < N; j++) begin
                if (req[j] && (j == (int'(ptr) + off) % N)) begin
                    gnt     = '0;
                    gnt[j]  = 1'b1;
                    ptr_nxt = IDXW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined 8x8 multiplier among NUM_REQ requesters with one op
// outstanding each. Define MULT_SHARE_STATS_EN to add issue/stall counters.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int unsigned NUM_REQ  = NUM_REQ_DEFAULT,
    parameter int unsigned PIPE_LAT = PIPE_LAT_DEFAULT
) (
    input  logic                     CLK_50M,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [OPW*NUM_REQ-1:0]   req_x,
    input  logic [OPW*NUM_REQ-1:0]   req_y,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [OPW-1:0]           mul_x,
    output logic [OPW-1:0]           mul_y,
    output logic                     mul_vld,
    input  logic [PRODW-1:0]         mul_p,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [PRODW*NUM_REQ-1:0] rsp_data,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic                     idle
`ifdef MULT_SHARE_STATS_EN
    ,
    output logic [15:0]              stat_issues,
    output logic [15:0]              stat_stall
`endif
);

    logic [NUM_REQ-1:0] busy_q;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] rsp_hs;
    logic [IDXW-1:0]    ptr_q;
    logic [IDXW-1:0]    ptr_nxt;
    logic [IDXW-1:0]    mul_idx_q;
    logic [OPW-1:0]     sel_x;
    logic [OPW-1:0]     sel_y;
    logic               accept;
    tag_t               pipe_q [PIPE_LAT];
    tag_t               pipe_out;

    // A requester stays ineligible through its own response handshake cycle.
    assign eligible  = req_valid & ~busy_q;
    assign req_ready = grant;
    assign accept    = |grant;
    assign rsp_hs    = rsp_valid & rsp_ready;
    assign pipe_out  = pipe_q[PIPE_LAT-1];
    assign idle      = ~|busy_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req     (eligible),
        .ptr     (ptr_q),
        .gnt     (grant),
        .ptr_nxt (ptr_nxt)
    );

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant[i]) begin
                sel_x = req_x[i*OPW +: OPW];
                sel_y = req_y[i*OPW +: OPW];
            end
        end
    end

    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= IDXW'(NUM_REQ - 1);
            busy_q    <= '0;
            mul_x     <= '0;
            mul_y     <= '0;
            mul_vld   <= 1'b0;
            mul_idx_q <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            for (int k = 0; k < int'(PIPE_LAT); k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            ptr_q     <= ptr_nxt;
            busy_q    <= (busy_q | grant) & ~rsp_hs;
            mul_vld   <= accept;
            mul_x     <= sel_x;
            mul_y     <= sel_y;
            mul_idx_q <= ptr_nxt;
            // Tag enters alongside the operands so it exits with the product.
            pipe_q[0] <= '{vld: mul_vld, idx: mul_idx_q};
            for (int k = 1; k < int'(PIPE_LAT); k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (rsp_hs[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
                if (pipe_out.vld && pipe_out.idx == IDXW'(i)) begin
                    rsp_valid[i]                 <= 1'b1;
                    rsp_data[i*PRODW +: PRODW] <= mul_p;
                end
            end
        end
    end

`ifdef MULT_SHARE_STATS_EN
    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            stat_issues <= '0;
            stat_stall  <= '0;
        end else begin
            if (accept && stat_issues != 16'hFFFF) begin
                stat_issues <= stat_issues + 16'd1;
            end
            if (|req_valid && !accept && stat_stall != 16'hFFFF) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a queue-based behavioural model.
module tb_mult_share_arbiter;

    localparam int N   = 4;
    localparam int LAT = 4;

    logic            CLK_50M = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [8*N-1:0]  req_x, req_y;
    logic [7:0]      mul_x, mul_y;
    logic            mul_vld;
    logic [15:0]     mul_p;
    logic [16*N-1:0] rsp_data;
    logic            idle;
`ifdef MULT_SHARE_STATS_EN
    logic [15:0]     stat_issues, stat_stall;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #10 CLK_50M = ~CLK_50M;

    mult_share_arbiter #(
        .NUM_REQ  (N),
        .PIPE_LAT (LAT)
    ) dut (
        .CLK_50M   (CLK_50M),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_vld   (mul_vld),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .idle      (idle)
`ifdef MULT_SHARE_STATS_EN
        ,
        .stat_issues (stat_issues),
        .stat_stall  (stat_stall)
`endif
    );

    // Environment multiplier with LAT cycles of latency.
    logic [15:0] mpipe [LAT];
    always @(posedge CLK_50M) begin
        mpipe[0] <= 16'(mul_x) * 16'(mul_y);
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_p = mpipe[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int due; int idx; int val; } ev_t;
    ev_t         evq[$];
    logic [N-1:0] m_busy, m_rv, elig, exp_gnt;
    logic [15:0] m_rd [N];
    int          m_ptr, widx, cyc, m_iss, m_stall;
    logic        m_mvld;
    logic [7:0]  m_mx, m_my;

    always @(negedge CLK_50M) begin
        if (!rst_n) begin
            chk("rst_req_ready", 64'(req_ready), 0);
            chk("rst_mul_vld", 64'(mul_vld), 0);
            chk("rst_mul_xy", {48'd0, mul_x, mul_y}, 0);
            chk("rst_rsp_valid", 64'(rsp_valid), 0);
            chk("rst_rsp_data", 64'(rsp_data), 0);
            chk("rst_idle", 64'(idle), 1);
            m_busy = '0; m_rv = '0; m_ptr = N - 1; m_mvld = 1'b0; m_mx = '0; m_my = '0;
            for (int i = 0; i < N; i++) m_rd[i] = '0;
            evq.delete();
            m_iss = 0; m_stall = 0;
        end else begin
            elig = req_valid & ~m_busy;
            widx = -1;
            for (int off = N; off > 0; off--) if (elig[(m_ptr + off) % N]) widx = (m_ptr + off) % N;
            exp_gnt = '0;
            if (widx >= 0) exp_gnt[widx] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_gnt));
            chk("mul_vld", 64'(mul_vld), 64'(m_mvld));
            chk("mul_x", 64'(mul_x), 64'(m_mx));
            chk("mul_y", 64'(mul_y), 64'(m_my));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
            for (int i = 0; i < N; i++)
                chk($sformatf("rsp_data%0d", i), 64'(rsp_data[i*16 +: 16]), 64'(m_rd[i]));
            chk("idle", 64'(idle), 64'(m_busy == '0));
`ifdef MULT_SHARE_STATS_EN
            chk("stat_issues", 64'(stat_issues), 64'(m_iss));
            chk("stat_stall", 64'(stat_stall), 64'(m_stall));
            if (widx >= 0 && m_iss < 65535) m_iss++;
            if (|req_valid && widx < 0 && m_stall < 65535) m_stall++;
`endif
            for (int i = 0; i < N; i++) if (m_rv[i] && rsp_ready[i]) begin
                m_rv[i] = 1'b0; m_busy[i] = 1'b0;
            end
            if (widx >= 0) begin
                m_busy[widx] = 1'b1;
                m_ptr  = widx;
                m_mvld = 1'b1;
                m_mx   = req_x[widx*8 +: 8];
                m_my   = req_y[widx*8 +: 8];
                evq.push_back('{due: cyc + LAT + 2, idx: widx, val: int'(m_mx) * int'(m_my)});
            end else begin
                m_mvld = 1'b0; m_mx = '0; m_my = '0;
            end
            for (int e = evq.size() - 1; e >= 0; e--) if (evq[e].due == cyc + 1) begin
                m_rv[evq[e].idx] = 1'b1;
                m_rd[evq[e].idx] = 16'(evq[e].val);
                evq.delete(e);
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int i, input int x, input int y);
        req_x[i*8 +: 8] = 8'(x);
        req_y[i*8 +: 8] = 8'(y);
        req_valid[i]    = 1'b1;
    endtask

    task automatic wait_grant(input int i, input string name);
        int k;
        k = 0;
        @(negedge CLK_50M);
        while (!req_ready[i] && k < 30) begin
            @(negedge CLK_50M);
            k++;
        end
        chk(name, 64'(req_ready[i]), 1);
    endtask

    task automatic reset_pulse();
        @(posedge CLK_50M); #1 rst_n = 1'b0;
        @(posedge CLK_50M); #1 rst_n = 1'b1;
    endtask

    function automatic logic [7:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 8'd0;
            1:       return 8'd255;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    int           lat, g0, g3;
    int           gseq[$], gcyc[$];
    logic [N-1:0] acc, pend;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_x = '0; req_y = '0; rsp_ready = '0;
        repeat (2) @(negedge CLK_50M);
        chk("reset_idle", 64'(idle), 1);
        @(posedge CLK_50M); #1 rst_n = 1'b1; rsp_ready = '1;

        // Single op: 12*13, six-cycle accept-to-response latency
        @(posedge CLK_50M); #1 drive(0, 12, 13);
        wait_grant(0, "t1_grant");
        @(posedge CLK_50M); #1 req_valid[0] = 1'b0;
        @(negedge CLK_50M);
        chk("t1_mul_vld", 64'(mul_vld), 1);
        chk("t1_mul_x", 64'(mul_x), 12);
        chk("t1_mul_y", 64'(mul_y), 13);
        lat = 1;
        while (!rsp_valid[0] && lat < 20) begin
            @(negedge CLK_50M);
            lat++;
        end
        chk("t1_latency", 64'(lat), 6);
        chk("t1_data", 64'(rsp_data[15:0]), 156);

        // Burst from reset pointer: grants 0..3, responses back to back
        reset_pulse();
        @(posedge CLK_50M); #1;
        for (int i = 0; i < N; i++) drive(i, 255, (i == 1) ? 0 : 255);
        for (int g = 0; g < N; g++) begin
            @(negedge CLK_50M);
            chk($sformatf("t2_grant%0d", g), 64'(req_ready), 64'(1 << g));
            @(posedge CLK_50M); #1 req_valid[g] = 1'b0;
        end
        repeat (2) @(negedge CLK_50M);
        for (int g = 0; g < N; g++) begin
            @(negedge CLK_50M);
            chk($sformatf("t2_rsp_valid%0d", g), 64'(rsp_valid), 64'(1 << g));
            chk($sformatf("t2_rsp_data%0d", g), 64'(rsp_data[g*16 +: 16]), (g == 1) ? 0 : 65025);
        end

        // Fairness: 0 and 2 re-request forever
        @(posedge CLK_50M); #1 drive(0, 3, 4); drive(2, 5, 6);
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK_50M);
            if (req_ready[0]) begin gseq.push_back(0); gcyc.push_back(k); end
            if (req_ready[2]) begin gseq.push_back(2); gcyc.push_back(k); end
        end
        chk("t3_grant_count", 64'(gseq.size() >= 8), 1);
        chk("t3_first", 64'(gseq[0]), 0);
        for (int j = 1; j < gseq.size(); j++)
            chk("t3_alternate", 64'(gseq[j] == gseq[j-1]), 0);
        for (int j = 2; j < gseq.size(); j++)
            chk("t3_gap", 64'(gcyc[j] - gcyc[j-2] >= LAT + 3), 1);
        @(posedge CLK_50M); #1 req_valid = '0;
        repeat (12) @(negedge CLK_50M);

        // Backpressure on requester 1
        @(posedge CLK_50M); #1 rsp_ready[1] = 1'b0; drive(1, 7, 9);
        wait_grant(1, "t4_grant");
        @(posedge CLK_50M); #1 req_valid[1] = 1'b0;
        lat = 0;
        while (!rsp_valid[1] && lat < 20) begin
            @(negedge CLK_50M);
            lat++;
        end
        chk("t4_rsp_arrived", 64'(rsp_valid[1]), 1);
        @(posedge CLK_50M); #1 drive(1, 2, 3); drive(0, 1, 1); drive(3, 4, 4);
        g0 = 0; g3 = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK_50M);
            chk("t4_hold_valid", 64'(rsp_valid[1]), 1);
            chk("t4_hold_data", 64'(rsp_data[31:16]), 63);
            chk("t4_blocked", 64'(req_ready[1]), 0);
            acc = req_ready;
            if (acc[0]) g0++;
            if (acc[3]) g3++;
            @(posedge CLK_50M); #1;
            if (acc[0]) req_valid[0] = 1'b0;
            if (acc[3]) req_valid[3] = 1'b0;
        end
        chk("t4_g0", 64'(g0), 1);
        chk("t4_g3", 64'(g3), 1);
        rsp_ready[1] = 1'b1;
        @(negedge CLK_50M);
        chk("t4_hs_no_grant", 64'(req_ready[1]), 0);
        @(negedge CLK_50M);
        chk("t4_regrant", 64'(req_ready[1]), 1);
        @(posedge CLK_50M); #1 req_valid[1] = 1'b0;
        repeat (10) @(negedge CLK_50M);

        // Reset with three ops in flight
        reset_pulse();
        @(posedge CLK_50M); #1 drive(0, 10, 10); drive(1, 11, 11); drive(2, 12, 12);
        for (int g = 0; g < 3; g++) begin
            @(negedge CLK_50M);
            chk($sformatf("t5_grant%0d", g), 64'(req_ready), 64'(1 << g));
            @(posedge CLK_50M); #1 req_valid[g] = 1'b0;
        end
        @(posedge CLK_50M); #1 rst_n = 1'b0;
        #1;
        chk("t5_req_ready", 64'(req_ready), 0);
        chk("t5_mul_vld", 64'(mul_vld), 0);
        chk("t5_rsp_valid", 64'(rsp_valid), 0);
        chk("t5_idle", 64'(idle), 1);
        repeat (2) @(posedge CLK_50M);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK_50M);
            chk("t5_no_rsp", 64'(rsp_valid), 0);
            chk("t5_idle_after", 64'(idle), 1);
        end

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK_50M);
            acc  = req_valid & req_ready;
            pend = req_valid & ~acc;
            @(posedge CLK_50M); #1;
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i]    = ($urandom_range(0, 2) != 0);
                    req_x[i*8 +: 8] = rnd_op();
                    req_y[i*8 +: 8] = rnd_op();
                end
                rsp_ready[i] = ($urandom_range(0, 3) != 0);
            end
        end
        req_valid = '0;
        rsp_ready = '1;
        repeat (20) @(negedge CLK_50M);
        chk("final_idle", 64'(idle), 1);

`ifdef MULT_SHARE_STATS_EN
        reset_pulse();
        @(negedge CLK_50M);
        chk("stat_issues_cleared", 64'(stat_issues), 0);
        chk("stat_stall_cleared", 64'(stat_stall), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
